decoding_block: RTL
===================

Name: decoding_block

Overview:
Receive-side counterpart of the lane encoder. It accepts one 66-bit (Gen2, 64b/66b) or 132-bit (Gen1, 128b/132b) encoded symbol per lane from the deserializer and checks the sync header. It then unpacks the payload into one byte per lane per enc_clk toward the logical-layer receive path. Gen0 traffic passes through byte-wise.

Parameters:
HDR2_DATA, 2'b01, Gen2 data sync header
HDR2_CTRL, 2'b10, Gen2 control sync header
HDR1_DATA, 4'b0101, Gen1 data sync header
HDR1_CTRL, 4'b1010, Gen1 control sync header

Ports:
enc_clk  in  1  clock
rst  in  1  asynchronous active-low reset
enable  in  1  synchronous clear when low
gen_speed  in  2  2=Gen2 (66b), 1=Gen1 (132b), 0=Gen0 pass-through, 3=reserved (ignored)
lane_0_rx_enc  in  132  lane 0 encoded symbol; Gen2 uses [65:0]; Gen0 uses [7:0]
lane_1_rx_enc  in  132  lane 1 encoded symbol, same layout
enc_valid  in  1  one-cycle strobe: both lane symbols valid
lane_0_rx  out  8  decoded lane 0 byte
lane_1_rx  out  8  decoded lane 1 byte
rx_valid  out  1  output bytes valid this cycle
rx_ctrl  out  1  current bytes belong to a control-header symbol
sym_start  out  1  high with byte 0 of each symbol
hdr_err  out  1  one-cycle pulse on an illegal or mismatched header
overflow  out  1  one-cycle pulse when a symbol is dropped

Behaviour:
- Reset is rst: asynchronous, active-low; clock is enc_clk. On reset, and on any edge with enable=0: all outputs 0, FSM to IDLE, pending buffer empty, byte_idx=0.
- Header field: Gen2 is lane_x_rx_enc[1:0]; Gen1 is [3:0]. Payload byte k is [2+8k+7 : 2+8k] for Gen2, k=0..7, and [4+8k+7 : 4+8k] for Gen1, k=0..15. Byte 0 is emitted first.
- Header check, per symbol: both lanes must carry the same legal header (DATA or CTRL) for the captured speed. Otherwise hdr_err pulses on the cycle after capture. The symbol is discarded: no rx_valid and no state change.
- gen_speed is sampled at capture and stored as spd_reg. Changing gen_speed mid-symbol does not affect the symbol in flight. gen_speed=3 means enc_valid is ignored.
- FSM has two states, IDLE and UNPACK:
  - IDLE + enc_valid + good header: load the shift register, set rx_ctrl from the header, byte_idx=0, go to UNPACK.
  - UNPACK: each cycle drive byte byte_idx with rx_valid=1, then increment byte_idx. sym_start=1 when byte_idx=0.
  - At the last byte (7 for Gen2, 15 for Gen1):
    - If the pending buffer is full, load it back-to-back, so the next cycle is byte 0 with no bubble.
    - Else, if enc_valid is high that cycle with a good header, load it directly.
    - Else go to IDLE.
- Latency: enc_valid at edge N gives byte 0 registered at output after edge N+1. A Gen2 symbol occupies 8 output cycles; a Gen1 symbol occupies 16.
- Pending buffer is one deep and holds both lanes plus the header type. enc_valid during UNPACK when not at the last byte stores the symbol in pending, after the header check.
  - If pending is already full, the new symbol is dropped: overflow pulses and pending is unchanged.
  - If enc_valid arrives at the last byte while pending is full: pending loads into the shift register and the new symbol goes into pending. There is no drop.
- A bad header arriving during UNPACK raises hdr_err only. It never touches pending or the current symbol.
- Gen0: each enc_valid drives lane_x_rx <= lane_x_rx_enc[7:0] with rx_valid=1 and sym_start=1 the next cycle. There is no header check, and rx_ctrl=0. Entering Gen0 capture flushes pending.
- When rx_valid=0, lane outputs hold their last value. rx_ctrl holds until the next capture.
- enable low or rst mid-symbol aborts immediately. Remaining bytes are lost and there is no error pulse.

Test Plan:
- Gen2 data: lane0 payload 64'h0807060504030201 with header 01, one enc_valid -> over 8 cycles lane_0_rx = 01..08, rx_ctrl=0, sym_start only on 01, rx_valid low afterwards.
- Gen1 control back-to-back: two symbols with header 1010, second enc_valid 10 cycles after the first -> 32 contiguous rx_valid cycles, rx_ctrl=1, sym_start at cycles 1 and 17, no overflow.
- Header errors: Gen2 header 2'b11 -> hdr_err pulse, rx_valid stays 0. Lane0=01 with lane1=10 -> hdr_err pulse.
- Overflow: Gen2, enc_valid at cycles 0, 2 and 4 -> symbol at cycle 4 dropped, overflow pulse at cycle 5, then 16 bytes total output.
- Gen0: enc_valid with lane_0_rx_enc[7:0]=8'hA5 and lane_1=8'h5A -> next cycle lane outputs A5/5A, rx_valid=1.
- Abort: Gen1 symbol, rst low at byte 5 -> all outputs 0 asynchronously. A symbol sent after rst rises decodes from byte 0, with no stale pending data.

Source files
------------

// File: rtl/decoding_block.sv
// Receive-side lane decoder: checks 64b/66b or 128b/132b sync headers and unpacks
// each symbol into one byte per lane per enc_clk; Gen0 bytes pass straight through.
module decoding_block #(
    parameter logic [1:0] HDR2_DATA = 2'b01,
    parameter logic [1:0] HDR2_CTRL = 2'b10,
    parameter logic [3:0] HDR1_DATA = 4'b0101,
    parameter logic [3:0] HDR1_CTRL = 4'b1010
) (
    input  logic         enc_clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [1:0]   gen_speed,
    input  logic [131:0] lane_0_rx_enc,
    input  logic [131:0] lane_1_rx_enc,
    input  logic         enc_valid,
    output logic [7:0]   lane_0_rx,
    output logic [7:0]   lane_1_rx,
    output logic         rx_valid,
    output logic         rx_ctrl,
    output logic         sym_start,
    output logic         hdr_err,
    output logic         overflow
);

    typedef enum logic {IDLE, UNPACK} state_t;

    state_t       state;
    logic [1:0]   spd_reg;
    logic [1:0]   pend_spd;
    logic [3:0]   byte_idx;
    logic         cur_ctrl;
    logic         pend_full;
    logic         pend_ctrl;
    logic [127:0] sh_0, sh_1, pend_0, pend_1;

    logic [1:0] chk;
    logic       cap, cap_ok, gen0_cap, at_last;
    logic       load_new, load_pend, store_pend, drop;

    // Returns {legal, is_ctrl}; both lanes must agree on a legal header.
    function automatic logic [1:0] hdr_chk(input logic [1:0] spd,
                                           input logic [131:0] a,
                                           input logic [131:0] b);
        logic ok, ctrl;
        ok   = 1'b0;
        ctrl = 1'b0;
        if (spd == 2'd2) begin
            ok   = (a[1:0] == b[1:0]) && (a[1:0] == HDR2_DATA || a[1:0] == HDR2_CTRL);
            ctrl = (a[1:0] == HDR2_CTRL);
        end else if (spd == 2'd1) begin
            ok   = (a[3:0] == b[3:0]) && (a[3:0] == HDR1_DATA || a[3:0] == HDR1_CTRL);
            ctrl = (a[3:0] == HDR1_CTRL);
        end
        return {ok, ctrl};
    endfunction

    // Payload right-aligned so byte k always sits at [8k+7:8k].
    function automatic logic [127:0] payload(input logic [1:0] spd, input logic [131:0] a);
        if (spd == 2'd2)
            return {64'd0, a[65:2]};
        return a[131:4];
    endfunction

    always_comb begin
        chk        = hdr_chk(gen_speed, lane_0_rx_enc, lane_1_rx_enc);
        cap        = enable && enc_valid && (gen_speed == 2'd1 || gen_speed == 2'd2);
        cap_ok     = cap && chk[1];
        gen0_cap   = enable && enc_valid && (gen_speed == 2'd0);
        at_last    = (state == UNPACK) && (byte_idx == ((spd_reg == 2'd2) ? 4'd7 : 4'd15));
        load_new   = 1'b0;
        load_pend  = 1'b0;
        store_pend = 1'b0;
        drop       = 1'b0;
        if (!gen0_cap) begin
            if (state == IDLE) begin
                load_new = cap_ok;
            end else if (at_last) begin
                if (pend_full) begin
                    load_pend  = 1'b1;
                    store_pend = cap_ok;
                end else begin
                    load_new = cap_ok;
                end
            end else if (cap_ok) begin
                drop       = pend_full;
                store_pend = !pend_full;
            end
        end
    end

    // Payload storage carries no reset; validity lives in state/pend_full.
    always_ff @(posedge enc_clk) begin
        if (load_new) begin
            sh_0 <= payload(gen_speed, lane_0_rx_enc);
            sh_1 <= payload(gen_speed, lane_1_rx_enc);
        end else if (load_pend) begin
            sh_0 <= pend_0;
            sh_1 <= pend_1;
        end else if (state == UNPACK) begin
            sh_0 <= {8'd0, sh_0[127:8]};
            sh_1 <= {8'd0, sh_1[127:8]};
        end
        if (store_pend) begin
            pend_0 <= payload(gen_speed, lane_0_rx_enc);
            pend_1 <= payload(gen_speed, lane_1_rx_enc);
        end
    end

    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            spd_reg   <= 2'd0;
            pend_spd  <= 2'd0;
            byte_idx  <= 4'd0;
            cur_ctrl  <= 1'b0;
            pend_full <= 1'b0;
            pend_ctrl <= 1'b0;
            lane_0_rx <= 8'd0;
            lane_1_rx <= 8'd0;
            rx_valid  <= 1'b0;
            rx_ctrl   <= 1'b0;
            sym_start <= 1'b0;
            hdr_err   <= 1'b0;
            overflow  <= 1'b0;
        end else if (!enable) begin
            state     <= IDLE;
            spd_reg   <= 2'd0;
            pend_spd  <= 2'd0;
            byte_idx  <= 4'd0;
            cur_ctrl  <= 1'b0;
            pend_full <= 1'b0;
            pend_ctrl <= 1'b0;
            lane_0_rx <= 8'd0;
            lane_1_rx <= 8'd0;
            rx_valid  <= 1'b0;
            rx_ctrl   <= 1'b0;
            sym_start <= 1'b0;
            hdr_err   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            sym_start <= 1'b0;
            hdr_err   <= cap && !chk[1];
            overflow  <= drop;
            if (gen0_cap) begin
                lane_0_rx <= lane_0_rx_enc[7:0];
                lane_1_rx <= lane_1_rx_enc[7:0];
                rx_valid  <= 1'b1;
                sym_start <= 1'b1;
                rx_ctrl   <= 1'b0;
                pend_full <= 1'b0;
                byte_idx  <= 4'd0;
                state     <= IDLE;
            end else begin
                if (state == UNPACK) begin
                    lane_0_rx <= sh_0[7:0];
                    lane_1_rx <= sh_1[7:0];
                    rx_valid  <= 1'b1;
                    sym_start <= (byte_idx == 4'd0);
                    rx_ctrl   <= cur_ctrl;
                    byte_idx  <= byte_idx + 4'd1;
                end
                if (load_new) begin
                    state    <= UNPACK;
                    spd_reg  <= gen_speed;
                    cur_ctrl <= chk[0];
                    byte_idx <= 4'd0;
                end else if (load_pend) begin
                    state    <= UNPACK;
                    spd_reg  <= pend_spd;
                    cur_ctrl <= pend_ctrl;
                    byte_idx <= 4'd0;
                end else if (at_last) begin
                    state <= IDLE;
                end
                // A symbol arriving on the reload edge takes the slot just vacated.
                if (store_pend) begin
                    pend_full <= 1'b1;
                    pend_spd  <= gen_speed;
                    pend_ctrl <= chk[0];
                end else if (load_pend) begin
                    pend_full <= 1'b0;
                end
            end
        end
    end

endmodule
